// File: rtl/piso_tx_ctrl_pkg.sv
// Shared definitions for the PISO transmit sequencer: FSM state encodings
// and the counter width helper.
package piso_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // A counter that must hold 0..n-1 needs $clog2(n) bits, but never fewer than one.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_tx_ctrl_if.sv
// Word handshake and serial framing bundle between a word producer,
// the transmit sequencer and the serial link.
interface piso_tx_ctrl_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             in_ready;
    logic             abort;
    logic             q;
    logic             q_valid;
    logic             busy;
    logic             done;

    modport master (
        output in, in_valid, abort,
        input  in_ready, q, q_valid, busy, done
    );

    modport slave (
        input  in, in_valid, abort,
        output in_ready, q, q_valid, busy, done
    );
endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out shift register with load, shift-enable and clear.
// Load wins over shift so a back-to-back word can replace the outgoing one.
module piso_shift_reg #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             sh_en,
    input  logic             clr,
    input  logic [WIDTH-1:0] in,
    output logic             q
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sr <= '0;
        end else if (ld) begin
            sr <= in;
        end else if (sh_en) begin
            if (MSB_FIRST)
                sr <= {sr[WIDTH-2:0], 1'b0};
            else
                sr <= {1'b0, sr[WIDTH-1:1]};
        end
    end

    assign q = MSB_FIRST ? sr[WIDTH-1] : sr[0];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Transmit sequencer: accepts words over valid/ready, serialises them through
// the PISO shifter and frames each word with q_valid/done plus an idle gap.
module piso_tx_ctrl
    import piso_ctrl_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 1,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    piso_tx_ctrl_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);
    localparam int GW = cnt_width(GAP_CYCLES);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t          state, state_nxt;
    logic [CW-1:0]   bit_cnt, bit_cnt_nxt;
    logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
    logic            ld, sh_en, clr;
    logic            last_bit, transfer, sr_q;

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk   (clk),
        .rst   (rst),
        .ld    (ld),
        .sh_en (sh_en),
        .clr   (clr),
        .in    (bus.in),
        .q     (sr_q)
    );

    assign last_bit = (state == ST_SHIFT) && (bit_cnt == BIT_LAST);
    // With no gap, the last bit cycle doubles as the acceptance window for the next word.
    assign bus.in_ready = !bus.abort &&
                          ((state == ST_IDLE) || ((GAP_CYCLES == 0) && last_bit));
    assign transfer = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = '0;
        gap_cnt_nxt = '0;
        ld          = 1'b0;
        sh_en       = 1'b0;
        clr         = 1'b0;
        if (bus.abort && (state != ST_IDLE)) begin
            state_nxt = ST_IDLE;
            clr       = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (transfer) begin
                        state_nxt = ST_SHIFT;
                        ld        = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    sh_en = 1'b1;
                    if (last_bit) begin
                        if (GAP_CYCLES > 0) begin
                            state_nxt = ST_GAP;
                        end else if (transfer) begin
                            state_nxt = ST_SHIFT;
                            ld        = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST)
                        state_nxt = ST_IDLE;
                    else
                        gap_cnt_nxt = gap_cnt + 1'b1;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign bus.q_valid = (state == ST_SHIFT);
    assign bus.q       = bus.q_valid & sr_q;
    assign bus.busy    = (state != ST_IDLE);
    assign bus.done    = last_bit;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Directed bench for piso_tx_ctrl: three instances cover gap/LSB-first,
// back-to-back and MSB-first configurations; outputs packed {in_ready,q,q_valid,busy,done}.
module tb_piso_tx_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    piso_tx_ctrl_if #(.WIDTH(4)) a_bus ();
    piso_tx_ctrl_if #(.WIDTH(4)) b_bus ();
    piso_tx_ctrl_if #(.WIDTH(4)) c_bus ();

    piso_tx_ctrl #(.WIDTH(4), .GAP_CYCLES(1), .MSB_FIRST(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(a_bus));
    piso_tx_ctrl #(.WIDTH(4), .GAP_CYCLES(0), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(b_bus));
    piso_tx_ctrl #(.WIDTH(4), .GAP_CYCLES(1), .MSB_FIRST(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(c_bus));

    function automatic logic [4:0] obs(input int sel);
        case (sel)
            0:       return {a_bus.in_ready, a_bus.q, a_bus.q_valid, a_bus.busy, a_bus.done};
            1:       return {b_bus.in_ready, b_bus.q, b_bus.q_valid, b_bus.busy, b_bus.done};
            default: return {c_bus.in_ready, c_bus.q, c_bus.q_valid, c_bus.busy, c_bus.done};
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%b expected=%b ({in_ready,q,q_valid,busy,done})", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, then sample the selected DUT.
    task automatic applyStimulus(input int sel, input logic v, input logic [3:0] d,
                                 input logic ab, input logic r,
                                 input logic [4:0] exp, input string tag);
        @(posedge clk);
        #1;
        rst            = r;
        a_bus.in       = d;
        b_bus.in       = d;
        c_bus.in       = d;
        a_bus.in_valid = (sel == 0) && v;
        b_bus.in_valid = (sel == 1) && v;
        c_bus.in_valid = (sel == 2) && v;
        a_bus.abort    = (sel == 0) && ab;
        b_bus.abort    = (sel == 1) && ab;
        c_bus.abort    = (sel == 2) && ab;
        #1;
        checkOutput(tag, obs(sel), exp);
    endtask

    initial begin
        a_bus.in = '0; a_bus.in_valid = 1'b0; a_bus.abort = 1'b0;
        b_bus.in = '0; b_bus.in_valid = 1'b0; b_bus.abort = 1'b0;
        c_bus.in = '0; c_bus.in_valid = 1'b0; c_bus.abort = 1'b0;
        $display("[TB] start");

        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_a", obs(0), 5'b10000);
        checkOutput("rst_b", obs(1), 5'b10000);
        checkOutput("rst_c", obs(2), 5'b10000);

        // 4'b1011 LSB first with one gap cycle
        applyStimulus(0, 1, 4'hB, 0, 0, 5'b10000, "t1_accept");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b01110, "t1_bit0");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b01110, "t1_bit1");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b00110, "t1_bit2");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b01111, "t1_bit3_done");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b00010, "t1_gap");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b10000, "t1_idle");

        // abort on 2nd bit of 4'hF
        applyStimulus(0, 1, 4'hF, 0, 0, 5'b10000, "t4_accept");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b01110, "t4_bit0");
        applyStimulus(0, 0, 4'h0, 1, 0, 5'b01110, "t4_bit1_abort");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b10000, "t4_after_abort");
        // abort with in_valid while idle blocks the transfer
        applyStimulus(0, 1, 4'hF, 1, 0, 5'b00000, "t4_idle_abort");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b10000, "t4_no_transfer");
        // abort on the last bit still shows done, and skips the gap
        applyStimulus(0, 1, 4'h8, 0, 0, 5'b10000, "t4l_accept");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b00110, "t4l_bit0");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b00110, "t4l_bit1");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b00110, "t4l_bit2");
        applyStimulus(0, 0, 4'h0, 1, 0, 5'b01111, "t4l_bit3_abort");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b10000, "t4l_idle");

        // rst pulsed on 3rd bit of 4'hB, then 4'h6 sent intact
        applyStimulus(0, 1, 4'hB, 0, 0, 5'b10000, "t5_accept");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b01110, "t5_bit0");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b01110, "t5_bit1");
        applyStimulus(0, 0, 4'h0, 0, 1, 5'b00110, "t5_bit2_rst");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b10000, "t5_after_rst");
        applyStimulus(0, 1, 4'h6, 0, 0, 5'b10000, "t5_accept2");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b00110, "t5_w2_bit0");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b01110, "t5_w2_bit1");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b01110, "t5_w2_bit2");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b00111, "t5_w2_bit3");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b00010, "t5_w2_gap");

        // 4'h3 held valid during 4'hC, accepted only once idle
        applyStimulus(0, 1, 4'hC, 0, 0, 5'b10000, "t6_accept");
        applyStimulus(0, 1, 4'h3, 0, 0, 5'b00110, "t6_bit0");
        applyStimulus(0, 1, 4'h3, 0, 0, 5'b00110, "t6_bit1");
        applyStimulus(0, 1, 4'h3, 0, 0, 5'b01110, "t6_bit2");
        applyStimulus(0, 1, 4'h3, 0, 0, 5'b01111, "t6_bit3");
        applyStimulus(0, 1, 4'h3, 0, 0, 5'b00010, "t6_gap");
        applyStimulus(0, 1, 4'h3, 0, 0, 5'b10000, "t6_accept2");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b01110, "t6_w2_bit0");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b01110, "t6_w2_bit1");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b00110, "t6_w2_bit2");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b00111, "t6_w2_bit3");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b00010, "t6_w2_gap");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b10000, "t6_idle");
        applyStimulus(0, 0, 4'h0, 0, 0, 5'b10000, "t6_once");

        // no gap: 4'hA then 4'h5 back to back
        applyStimulus(1, 1, 4'hA, 0, 0, 5'b10000, "t2_accept");
        applyStimulus(1, 1, 4'h5, 0, 0, 5'b00110, "t2_bit0");
        applyStimulus(1, 1, 4'h5, 0, 0, 5'b01110, "t2_bit1");
        applyStimulus(1, 1, 4'h5, 0, 0, 5'b00110, "t2_bit2");
        applyStimulus(1, 1, 4'h5, 0, 0, 5'b11111, "t2_bit3_accept");
        applyStimulus(1, 0, 4'h0, 0, 0, 5'b01110, "t2_w2_bit0");
        applyStimulus(1, 0, 4'h0, 0, 0, 5'b00110, "t2_w2_bit1");
        applyStimulus(1, 0, 4'h0, 0, 0, 5'b01110, "t2_w2_bit2");
        applyStimulus(1, 0, 4'h0, 0, 0, 5'b10111, "t2_w2_bit3");
        applyStimulus(1, 0, 4'h0, 0, 0, 5'b10000, "t2_idle");

        // MSB first: 4'b1000
        applyStimulus(2, 1, 4'h8, 0, 0, 5'b10000, "t3_accept");
        applyStimulus(2, 0, 4'h0, 0, 0, 5'b01110, "t3_bit0");
        applyStimulus(2, 0, 4'h0, 0, 0, 5'b00110, "t3_bit1");
        applyStimulus(2, 0, 4'h0, 0, 0, 5'b00110, "t3_bit2");
        applyStimulus(2, 0, 4'h0, 0, 0, 5'b00111, "t3_bit3_done");
        applyStimulus(2, 0, 4'h0, 0, 0, 5'b00010, "t3_gap");
        applyStimulus(2, 0, 4'h0, 0, 0, 5'b10000, "t3_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
